// File: rtl/esdi_drive_serial_responder_pkg.sv
// esdi_pkg: shared frame sizes, responder states and parity helper for the ESDI drive serial responder.
package esdi_pkg;
  localparam int ESDI_FRAME_BITS = 17;
  localparam int ESDI_WORD_BITS = 16;
  typedef enum logic [2:0] {IDLE, CMD_BIT, CMD_CHECK, WAIT_RESP, STAT_BIT, DONE} esdi_state_e;
  function automatic logic odd_parity(input logic [ESDI_WORD_BITS-1:0] w);
    return ~^w;
  endfunction
endpackage

// File: rtl/esdi_bit_handshake.sv
// esdi_bit_handshake: per-bit req/ack sequencing with ack delay and mid-frame timeout.
module esdi_bit_handshake #(
  parameter int ACK_DELAY = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic sreq_i,
  input  logic active_i,
  input  logic tmo_en_i,
  output logic bit_start_o,
  output logic bit_done_o,
  output logic timeout_o,
  output logic ack_o
);
  localparam int DW = $clog2(ACK_DELAY + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {H_RISE, H_UP, H_FALL, H_DN} phase_e;
  phase_e phase_q;
  logic [DW-1:0] dly_q;
  logic [TW-1:0] tmo_q;
  logic sreq_prev_q, seen_low_q, edge_w, abort_w, dly_hit;
  assign edge_w = sreq_i ^ sreq_prev_q;
  assign dly_hit = dly_q == DW'(ACK_DELAY - 1);
  assign timeout_o = tmo_en_i && !edge_w && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  assign abort_w = !active_i || timeout_o;
  // a rise is remembered as "seen low, now high" so one arriving while we are busy is taken later
  assign bit_start_o = !abort_w && phase_q == H_RISE && sreq_i && seen_low_q;
  assign bit_done_o = !abort_w && phase_q == H_DN && dly_hit;
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= H_RISE;
      dly_q <= '0;
      tmo_q <= '0;
      sreq_prev_q <= 1'b0;
      seen_low_q <= 1'b0;
      ack_o <= 1'b0;
    end else begin
      sreq_prev_q <= sreq_i;
      seen_low_q <= !sreq_i || (seen_low_q && !bit_start_o);
      tmo_q <= (!tmo_en_i || edge_w) ? '0 : tmo_q + TW'(1);
      dly_q <= ((phase_q == H_UP || phase_q == H_DN) && !dly_hit) ? dly_q + DW'(1) : '0;
      if (abort_w) begin
        phase_q <= H_RISE;
        ack_o <= 1'b0;
      end else begin
        case (phase_q)
          H_RISE: if (bit_start_o) phase_q <= H_UP;
          H_UP: if (dly_hit) begin
            ack_o <= 1'b1;
            phase_q <= H_FALL;
          end
          H_FALL: if (!sreq_i) phase_q <= H_DN;
          H_DN: if (dly_hit) begin
            ack_o <= 1'b0;
            phase_q <= H_RISE;
          end
          default: phase_q <= H_RISE;
        endcase
      end
    end
  end
endmodule

// File: rtl/esdi_drive_serial_responder.sv
// esdi_drive_serial_responder: drive-side ESDI serial command receiver and status transmitter.
module esdi_drive_serial_responder
  import esdi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_DELAY = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        transfer_req,
  input  logic        command_data,
  output logic        transfer_ack,
  output logic        confstat_data,
  output logic        command_complete,
  output logic        attention,
  output logic        cmd_valid,
  output logic [15:0] cmd_word,
  input  logic        resp_valid,
  input  logic        resp_has_data,
  input  logic [15:0] resp_word,
  output logic        abort_err
);
  logic [SYNC_STAGES-1:0] req_sync_q, data_sync_q;
  logic sreq, sdata, bit_start, bit_done, timeout, hs_active, tmo_en, last_bit;
  esdi_state_e state_q;
  logic [4:0] bit_cnt_q;
  logic [ESDI_FRAME_BITS-1:0] cmd_sr_q, stat_sr_q;
  assign sreq = req_sync_q[SYNC_STAGES-1];
  assign sdata = data_sync_q[SYNC_STAGES-1];
  assign hs_active = state_q == IDLE || state_q == CMD_BIT || state_q == STAT_BIT;
  assign tmo_en = state_q == CMD_BIT || state_q == STAT_BIT;
  assign last_bit = bit_cnt_q == 5'(ESDI_FRAME_BITS - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      req_sync_q <= '0;
      data_sync_q <= '0;
    end else begin
      req_sync_q <= (req_sync_q << 1) | SYNC_STAGES'(transfer_req);
      data_sync_q <= (data_sync_q << 1) | SYNC_STAGES'(command_data);
    end
  end
  esdi_bit_handshake #(
    .ACK_DELAY(ACK_DELAY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_hs (
    .clk(clk),
    .rst(rst),
    .sreq_i(sreq),
    .active_i(hs_active),
    .tmo_en_i(tmo_en),
    .bit_start_o(bit_start),
    .bit_done_o(bit_done),
    .timeout_o(timeout),
    .ack_o(transfer_ack)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      cmd_sr_q <= '0;
      stat_sr_q <= '0;
      confstat_data <= 1'b0;
      command_complete <= 1'b1;
      attention <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_word <= '0;
      abort_err <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      abort_err <= 1'b0;
      if (timeout) begin
        abort_err <= 1'b1;
        attention <= 1'b1;
        confstat_data <= 1'b0;
        state_q <= DONE;
      end else begin
        case (state_q)
          IDLE: if (bit_start) begin
            attention <= 1'b0;
            command_complete <= 1'b0;
            cmd_sr_q <= {cmd_sr_q[ESDI_FRAME_BITS-2:0], sdata};
            bit_cnt_q <= '0;
            state_q <= CMD_BIT;
          end
          CMD_BIT: begin
            if (bit_start) cmd_sr_q <= {cmd_sr_q[ESDI_FRAME_BITS-2:0], sdata};
            if (bit_done) begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (last_bit) state_q <= CMD_CHECK;
            end
          end
          CMD_CHECK: begin
            if (^cmd_sr_q) begin
              cmd_valid <= 1'b1;
              cmd_word <= cmd_sr_q[ESDI_FRAME_BITS-1:1];
              state_q <= WAIT_RESP;
            end else begin
              attention <= 1'b1;
              state_q <= DONE;
            end
          end
          WAIT_RESP: if (resp_valid) begin
            stat_sr_q <= {resp_word, odd_parity(resp_word)};
            bit_cnt_q <= '0;
            state_q <= resp_has_data ? STAT_BIT : DONE;
          end
          STAT_BIT: begin
            if (bit_start) begin
              confstat_data <= stat_sr_q[ESDI_FRAME_BITS-1];
              stat_sr_q <= {stat_sr_q[ESDI_FRAME_BITS-2:0], 1'b0};
            end
            if (bit_done) begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (last_bit) begin
                confstat_data <= 1'b0;
                state_q <= DONE;
              end
            end
          end
          DONE: begin
            command_complete <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/esdi_drive_serial_responder.md
Name: esdi_drive_serial_responder

Overview:
- Drive-side end of the ESDI serial command/status channel. Used to emulate a drive against our controller core on the bench and in the loopback bitstream.
- Receives 17-bit commands over TRANSFER REQ / COMMAND DATA and acks each bit on TRANSFER ACK.
- Returns 17-bit configuration/status words on CONFIG-STATUS DATA when local drive logic supplies them.
- Drives COMMAND COMPLETE and ATTENTION. All ESDI-side signals are active-high at this boundary; pad inversion lives in the top level.

Parameters:
- SYNC_STAGES, 2: flip-flop synchronizer depth on transfer_req and command_data.
- ACK_DELAY, 4: clk cycles from a detected req edge to the ack change (data setup margin).
- TIMEOUT_CYCLES, 65535: max clk cycles waiting on any controller req edge mid-frame before aborting.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- transfer_req  in  1  controller TRANSFER REQ (async, synchronized inside)
- command_data  in  1  controller COMMAND DATA (async, synchronized inside)
- transfer_ack  out  1  TRANSFER ACK to controller
- confstat_data  out  1  CONFIG-STATUS DATA to controller
- command_complete  out  1  COMMAND COMPLETE to controller
- attention  out  1  ATTENTION to controller
- cmd_valid  out  1  one-cycle pulse; cmd_word is valid
- cmd_word  out  16  received command, bit 15 = first bit on the wire
- resp_valid  in  1  local logic response strobe, accepted only in WAIT_RESP
- resp_has_data  in  1  with resp_valid: 1 = send resp_word, 0 = no data phase
- resp_word  in  16  status/config word, sampled on accepted resp_valid
- abort_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: transfer_ack=0, confstat_data=0, command_complete=1, attention=0, cmd_valid=0, cmd_word=0, abort_err=0. Reset mid-frame returns to IDLE the next cycle with these values.
- Synchronization: sreq and sdata are SYNC_STAGES-deep synchronized copies of the inputs. Edge detection runs on sreq.
- Frame format: 16 bits MSB first, then 1 parity bit. Odd parity: the count of ones over all 17 bits must be odd.
- IDLE: on sreq rise, clear attention, drop command_complete, and go to CMD_BIT.
- CMD_BIT: sample sdata on the sreq rising edge and shift it in.
  - ACK_DELAY cycles later, raise transfer_ack.
  - Wait for sreq fall, then ACK_DELAY cycles, then drop transfer_ack.
  - Wait for the next sreq rise. The bit counter is 5 bits and counts 0..16.
  - After bit 16's ack drops, go to CMD_CHECK.
- CMD_CHECK (1 cycle):
  - Parity good: pulse cmd_valid, load cmd_word, go to WAIT_RESP.
  - Parity bad: set attention, no cmd_valid, go to DONE.
- WAIT_RESP: hold until resp_valid. The timeout does not apply here.
  - resp_has_data=1: latch resp_word, compute its odd parity bit, go to STAT_BIT.
  - resp_has_data=0: go to DONE.
- STAT_BIT, per bit (17 bits, MSB first, parity last):
  - On sreq rise, place the bit on confstat_data.
  - ACK_DELAY cycles later, raise transfer_ack.
  - On sreq fall, wait ACK_DELAY cycles, then drop transfer_ack.
  - confstat_data holds until the next bit is driven and returns to 0 after the last ack drops.
- DONE: raise command_complete and go to IDLE.
- Timeout: in CMD_BIT or STAT_BIT, a counter resets on every sreq edge.
  - If it reaches TIMEOUT_CYCLES, pulse abort_err, set attention, drop ack and confstat_data, and go to DONE.
- Edge cases:
  - sreq toggling while ack is in its ACK_DELAY window is ignored until the ack change completes.
  - resp_valid outside WAIT_RESP is ignored.
  - An sreq rise in DONE is deferred to IDLE on the next cycle.

Decomposition:
- Package esdi_pkg holds:
  - ESDI_FRAME_BITS=17 and ESDI_WORD_BITS=16.
  - State enum {IDLE, CMD_BIT, CMD_CHECK, WAIT_RESP, STAT_BIT, DONE}.
  - An odd-parity function.
- One sub-module: esdi_bit_handshake. It owns the sreq edge detect, the ACK_DELAY counter, the transfer_ack sequencing and the timeout. It emits bit_start, bit_done and timeout strobes to the parent FSM.

Test Plan:
- Send command 0x5A3C with parity 1 (8 ones + 1 = odd) -> 17 ack pulses; cmd_valid pulses once with cmd_word=0x5A3C; command_complete low from the first req until DONE.
- Same command, then resp_valid with resp_has_data=1 and resp_word=0x8001, then 17 controller req cycles -> confstat_data reads 1,0×14,1 then parity 1; command_complete rises after the 17th ack falls.
- Command 0x0000 with parity 0 -> no cmd_valid; attention=1 after frame; next command's first req clears attention.
- Controller stops after bit 7 with TIMEOUT_CYCLES=100 -> abort_err pulses 100 cycles after the last edge; attention=1, transfer_ack=0, command_complete=1, FSM returns to IDLE.
- resp_has_data=0 -> no status phase; command_complete rises within 2 cycles of resp_valid.
- Assert rst during STAT_BIT bit 5 -> next cycle all outputs are at reset values; a following clean command is received correctly.
